mux_sel_debounce_toggle: RTL and testbench

//  Upstream control stage for the lab 2:1 mux: turns a raw board pushbutton into a clean select line.

---
 rtl/mux_sel_debounce_toggle.sv | 141 ++++++++++++++
 tb/tb_mux_sel_debounce_toggle.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_sel_debounce_toggle.sv
// mux_sel_debounce_toggle
//   Turns a raw, bouncy, asynchronous pushbutton into a clean select line for
//   the lab 2:1 mux. btn_in is synchronised, debounced by a four-state FSM with
//   a stability counter, and every accepted press toggles sel_out exactly once.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   btn_in       raw pushbutton level (active-high, asynchronous, bouncy)
//   sel_out      registered mux select, toggles once per accepted press
//   press_pulse  registered one-cycle pulse per accepted press
//   db_state     registered debounced button level
module mux_sel_debounce_toggle #(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   SYNC_STAGES     = 2,
    parameter logic SEL_RESET       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic sel_out,
    output logic press_pulse,
    output logic db_state
);

    if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_err
        $error("mux_sel_debounce_toggle: need DEBOUNCE_CYCLES>=1 and SYNC_STAGES>=2");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    // Synchroniser: plain shift chain, the last stage is the only consumer-visible bit.
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= '0;
        else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_in};
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          db_n, pulse_n, sel_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOW;
            cnt         <= '0;
            db_state    <= 1'b0;
            press_pulse <= 1'b0;
            sel_out     <= SEL_RESET;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            db_state    <= db_n;
            press_pulse <= pulse_n;
            sel_out     <= sel_n;
        end
    end

    // cnt holds the number of consecutive sync samples seen at the new level,
    // so a change is accepted on the DEBOUNCE_CYCLES-th stable sample.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        db_n    = db_state;
        pulse_n = 1'b0;
        sel_n   = sel_out;
        unique case (state)
            S_LOW: begin
                if (sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_n = S_HIGH;
                        cnt_n   = '0;
                        db_n    = 1'b1;
                        pulse_n = 1'b1;
                        sel_n   = ~sel_out;
                    end else begin
                        state_n = S_RISE;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            S_RISE: begin
                if (!sync) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                    db_n    = 1'b1;
                    pulse_n = 1'b1;
                    sel_n   = ~sel_out;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_n = S_LOW;
                        cnt_n   = '0;
                        db_n    = 1'b0;
                    end else begin
                        state_n = S_FALL;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            S_FALL: begin
                if (sync) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                    db_n    = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                // Corrupted state: restart cleanly, leave db_state/sel_out alone.
                state_n = S_LOW;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_sel_debounce_toggle.sv
// Bench for mux_sel_debounce_toggle with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Reference model: btn_in delayed SYNC_STAGES edges through a queue, then a
// run-length rule: the debounced level flips when the last D samples all
// disagree with it; a flip to 1 pulses and toggles sel.
module tb_mux_sel_debounce_toggle;
    localparam int D = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic sel_out, press_pulse, db_state;

    mux_sel_debounce_toggle #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S),
        .SEL_RESET      (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .sel_out    (sel_out),
        .press_pulse(press_pulse),
        .db_state   (db_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // model state
    logic mq[$];
    logic m_last, m_db, m_sel, m_pulse;
    int   m_run;

    typedef struct {
        logic       btn;
        int         n;
        logic [2:0] exp;   // {sel_out, press_pulse, db_state} after the last cycle
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: sel/pulse/db got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < S; i++) mq.push_back(1'b0);
        m_last  = 1'b0;
        m_run   = 0;
        m_db    = 1'b0;
        m_sel   = 1'b0;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_edge(input logic b);
        logic s;
        s = mq.pop_front();
        mq.push_back(b);
        if (s == m_last) m_run++;
        else begin
            m_last = s;
            m_run  = 1;
        end
        m_pulse = 1'b0;
        if (s != m_db && m_run >= D) begin
            m_db = s;
            if (s) begin
                m_pulse = 1'b1;
                m_sel   = ~m_sel;
            end
        end
    endfunction

    // Drive btn before the next rising edge, advance the model, compare at the falling edge.
    task automatic tick(input logic b, input string name);
        btn_in = b;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(b);
        @(negedge clk);
        if (press_pulse) pulses++;
        check(name, {sel_out, press_pulse, db_state}, {m_sel, m_pulse, m_db});
    endtask

    task automatic ticks(input logic b, input int n, input string name);
        for (int i = 0; i < n; i++) tick(b, name);
    endtask

    initial begin
        model_reset();
        tbl[0]  = '{1'b0, 3,  3'b000};
        tbl[1]  = '{1'b1, 5,  3'b000};  // edges 1..5 of a press: nothing yet
        tbl[2]  = '{1'b1, 1,  3'b111};  // edge 6: accept
        tbl[3]  = '{1'b1, 1,  3'b101};  // edge 7: pulse gone
        tbl[4]  = '{1'b1, 13, 3'b101};  // held: no auto-repeat
        tbl[5]  = '{1'b0, 5,  3'b101};
        tbl[6]  = '{1'b0, 1,  3'b100};  // release accepted at edge 6, sel kept
        tbl[7]  = '{1'b1, 3,  3'b100};  // short glitch
        tbl[8]  = '{1'b0, 10, 3'b100};
        tbl[9]  = '{1'b1, 6,  3'b011};  // second press toggles back
        tbl[10] = '{1'b1, 1,  3'b001};
        tbl[11] = '{1'b0, 6,  3'b000};

        // 1: reset held with the button chattering
        @(negedge clk);
        for (int i = 0; i < 8; i++) tick(i[0], "reset_hold");
        check("reset_state", {sel_out, press_pulse, db_state}, 3'b000);
        rst_n = 1'b1;

        // 2/4: table-driven clean press, release, glitch
        for (int i = 0; i < 12; i++) begin
            ticks(tbl[i].btn, tbl[i].n, "tbl_model");
            check($sformatf("tbl%0d", i), {sel_out, press_pulse, db_state}, tbl[i].exp);
        end

        // 3: bounce then steady high -> one toggle, 6 edges after final rise
        pulses = 0;
        ticks(1'b1, 3, "bounce"); tick(1'b0, "bounce");
        ticks(1'b1, 2, "bounce"); tick(1'b0, "bounce");
        ticks(1'b1, 5, "bounce");
        check("bounce_pre", {sel_out, press_pulse, db_state}, 3'b000);
        tick(1'b1, "bounce");
        check("bounce_edge6", {sel_out, press_pulse, db_state}, 3'b111);
        ticks(1'b1, 10, "bounce");
        check("bounce_pulses", 3'(pulses), 3'd1);
        ticks(1'b0, 10, "bounce_rel");

        // 4: glitch leaves everything alone
        ticks(1'b1, 3, "glitch");
        ticks(1'b0, 12, "glitch");
        check("glitch_end", {sel_out, press_pulse, db_state}, 3'b100);

        // 5: five presses from reset -> 1,0,1,0,1
        rst_n = 1'b0;
        ticks(1'b0, 2, "rst5");
        rst_n = 1'b1;
        pulses = 0;
        for (int p = 0; p < 5; p++) begin
            ticks(1'b1, 10, "press5");
            check($sformatf("press5_sel%0d", p), {2'b00, sel_out}, {2'b00, (p % 2 == 0)});
            ticks(1'b0, 10, "press5");
        end
        check("press5_pulses", 3'(pulses), 3'd5);

        // 6: async reset at cnt==2 in S_RISE with sel=1, button still held
        ticks(1'b1, 4, "rst_mid");
        #2 rst_n = 1'b0;
        #1 check("rst_async", {sel_out, press_pulse, db_state}, 3'b000);
        model_reset();
        ticks(1'b1, 2, "rst_mid_hold");
        rst_n = 1'b1;
        ticks(1'b1, 5, "rst_rel");
        check("rst_pre", {sel_out, press_pulse, db_state}, 3'b000);
        tick(1'b1, "rst_rel");
        check("rst_edge6", {sel_out, press_pulse, db_state}, 3'b111);
        ticks(1'b0, 8, "rst_rel");

        // random levels with random hold lengths around the debounce threshold
        for (int i = 0; i < 300; i++) begin
            logic b;
            int   n;
            b = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 7);
            ticks(b, n, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
